// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Also holds the virtual-to-physical map helper.
package ifetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_DONE  = 3'd5,
    S_DRAIN = 3'd6
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst1;
    logic [31:0] inst2;
  } fetch_pair_t;

  localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;
  localparam logic [31:0] RESET_PC       = 32'hBFC0_0000;

  function automatic logic [31:0] map_addr(
    input logic [31:0] va,
    input bit          map_kseg
  );
    return map_kseg ? (va & KSEG_PHYS_MASK) : va;
  endfunction

endpackage

// File: rtl/ifetch_timeout_ctr.sv
// Bus-wait timeout counter: counts while enabled, pulses at the
// last count; clear has priority over counting.
module ifetch_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic term
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = enable && (cnt == LAST);

endmodule

// File: rtl/ifetch_mem_responder.sv
// Memory side of instruction fetch: reads pc and pc+4 over an
// SRAM-like bus and hands IF one dual-issue pair.
module ifetch_mem_responder
  import ifetch_pkg::*;
#(
  parameter int TIMEOUT  = 64,
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic [31:0] fetch_pc_in,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_inst_1,
  output logic [31:0] if_inst_2,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid,
  output logic        delay_hard,
  output logic        IADEE,
  output logic        IADFE
);

  state_e      state;
  state_e      state_n;
  fetch_pair_t pair_q;
  logic        iadee_q;
  logic        iadee_n;
  logic        iadfe_q;
  logic        iadfe_n;
  logic        cap_pc;
  logic        cap_w1;
  logic        cap_w2;
  logic        tmo_en;
  logic        tmo_clr;
  logic        tmo;
  logic [31:0] pc_next;

  assign pc_next = pair_q.pc + 32'd4;

  always_comb begin
    state_n = state;
    cap_pc  = 1'b0;
    cap_w1  = 1'b0;
    cap_w2  = 1'b0;
    iadee_n = 1'b0;
    iadfe_n = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fetch_en && !flush) begin
          cap_pc = 1'b1;
          if (fetch_pc_in[1:0] != 2'b00) begin
            iadee_n = 1'b1;
          end else begin
            state_n = S_REQ0;
          end
        end
      end
      S_REQ0: begin
        if (flush) begin
          // data already in hand needs no drain
          state_n = (addr_ok && !data_ok) ? S_DRAIN : S_IDLE;
        end else if (addr_ok) begin
          cap_w1  = data_ok;
          state_n = data_ok ? S_REQ1 : S_WAIT0;
        end
      end
      S_WAIT0: begin
        if (data_ok) begin
          cap_w1  = !flush;
          state_n = flush ? S_IDLE : S_REQ1;
        end else if (flush) begin
          state_n = S_DRAIN;
        end else if (tmo) begin
          iadfe_n = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_REQ1: begin
        if (flush) begin
          state_n = (addr_ok && !data_ok) ? S_DRAIN : S_IDLE;
        end else if (addr_ok) begin
          cap_w2  = data_ok;
          state_n = data_ok ? S_DONE : S_WAIT1;
        end
      end
      S_WAIT1: begin
        if (data_ok) begin
          cap_w2  = !flush;
          state_n = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_n = S_DRAIN;
        end else if (tmo) begin
          iadfe_n = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      S_DRAIN: begin
        if (data_ok || tmo) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pair_q  <= '0;
      iadee_q <= 1'b0;
      iadfe_q <= 1'b0;
    end else begin
      state   <= state_n;
      iadee_q <= iadee_n;
      iadfe_q <= iadfe_n;
      if (cap_pc) pair_q.pc    <= fetch_pc_in;
      if (cap_w1) pair_q.inst1 <= inst_rdata;
      if (cap_w2) pair_q.inst2 <= inst_rdata;
    end
  end

  // bus-facing outputs decode from registered state only
  always_comb begin
    inst_req   = 1'b0;
    inst_addr  = '0;
    delay_hard = 1'b0;
    tmo_en     = 1'b0;
    unique case (state)
      S_REQ0: begin
        inst_req   = 1'b1;
        inst_addr  = map_addr(pair_q.pc, MAP_KSEG);
        delay_hard = 1'b1;
      end
      S_REQ1: begin
        inst_req   = 1'b1;
        inst_addr  = map_addr(pc_next, MAP_KSEG);
        delay_hard = 1'b1;
      end
      S_WAIT0, S_WAIT1, S_DRAIN: begin
        delay_hard = 1'b1;
        tmo_en     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign tmo_clr = data_ok || !tmo_en || (state_n != state);

  ifetch_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clear (tmo_clr),
    .enable(tmo_en),
    .term  (tmo)
  );

  assign fetch_valid = (state == S_DONE) && !flush;
  assign if_inst_1   = pair_q.inst1;
  assign if_inst_2   = pair_q.inst2;
  assign fetch_pc    = pair_q.pc;
  assign IADEE       = iadee_q;
  assign IADFE       = iadfe_q;

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// Scoreboard bench for ifetch_mem_responder with a randomized
// bus responder and a transaction-level expectation model.
module tb_ifetch_mem_responder;
  import ifetch_pkg::*;

  localparam int K_PAIR = 0;
  localparam int K_ADE  = 1;
  localparam int K_ADF  = 2;

  typedef struct {
    int          kind;
    logic [31:0] pc;
    logic [31:0] w1;
    logic [31:0] w2;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [31:0] fetch_pc_in;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] if_inst_1;
  logic [31:0] if_inst_2;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        delay_hard;
  logic        IADEE;
  logic        IADFE;

  logic        d0_req;
  logic [31:0] d0_addr;
  logic [31:0] d0_if1;
  logic [31:0] d0_if2;
  logic [31:0] d0_pc;
  logic        d0_fv;
  logic        d0_dh;
  logic        d0_ade;
  logic        d0_adf;

  int n_chk = 0;
  int n_err = 0;
  exp_t sb[$];

  int cfg_amin = 0, cfg_amax = 0;
  int cfg_dmin = 1, cfg_dmax = 1;
  bit dead_mode = 1'b0;
  bit bus_rst = 1'b0;

  logic [31:0] last_w1, last_w2;

  bit zw_req [0:6] = '{0, 1, 0, 1, 0, 0, 0};
  bit zw_dh  [0:6] = '{0, 1, 1, 1, 1, 0, 0};
  bit zw_fv  [0:6] = '{0, 0, 0, 0, 0, 1, 0};

  ifetch_mem_responder #(.TIMEOUT(8), .MAP_KSEG(1'b1)) u_dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .fetch_pc_in(fetch_pc_in), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .addr_ok(addr_ok), .data_ok(data_ok), .inst_rdata(inst_rdata),
    .if_inst_1(if_inst_1), .if_inst_2(if_inst_2),
    .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .delay_hard(delay_hard), .IADEE(IADEE), .IADFE(IADFE)
  );

  ifetch_mem_responder #(.TIMEOUT(8), .MAP_KSEG(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .fetch_pc_in(fetch_pc_in), .flush(flush),
    .inst_req(d0_req), .inst_addr(d0_addr),
    .addr_ok(addr_ok), .data_ok(data_ok), .inst_rdata(inst_rdata),
    .if_inst_1(d0_if1), .if_inst_2(d0_if2),
    .fetch_pc(d0_pc), .fetch_valid(d0_fv),
    .delay_hard(d0_dh), .IADEE(d0_ade), .IADFE(d0_adf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] phys(input logic [31:0] va);
    return {3'b000, va[28:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_pair(input logic [31:0] pc);
    logic [31:0] p4;
    exp_t e;
    p4 = pc + 32'd4;
    e.kind = K_PAIR;
    e.pc = pc;
    e.w1 = memf(phys(pc));
    e.w2 = memf(phys(p4));
    sb.push_back(e);
    last_w1 = e.w1;
    last_w2 = e.w2;
  endtask

  task automatic push_fault(input int kind, input logic [31:0] pc);
    exp_t e;
    e.kind = kind;
    e.pc = pc;
    e.w1 = '0;
    e.w2 = '0;
    sb.push_back(e);
  endtask

  task automatic set_cfg(input int amin, input int amax,
                         input int dmin, input int dmax,
                         input bit dead);
    cfg_amin = amin;
    cfg_amax = amax;
    cfg_dmin = dmin;
    cfg_dmax = dmax;
    dead_mode = dead;
    bus_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // bus responder: one outstanding request, random latencies
  initial begin
    bit          have_pend;
    int          a_cnt, a_tgt, d_left, lat;
    logic [31:0] pend_addr, prev_addr;
    bit          prev_req, prev_aok;
    have_pend = 0; a_cnt = 0; a_tgt = 0; d_left = 0;
    pend_addr = '0; prev_addr = '0; prev_req = 0; prev_aok = 0;
    addr_ok = 1'b0; data_ok = 1'b0; inst_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_rst) begin
        have_pend = 0;
        a_cnt = 0;
        a_tgt = int'($urandom_range(cfg_amax, cfg_amin));
        bus_rst = 1'b0;
      end
      addr_ok = 1'b0;
      data_ok = 1'b0;
      if (prev_req && !prev_aok && inst_req)
        chk("addr_hold", inst_addr, prev_addr);
      if (have_pend) begin
        d_left--;
        if (d_left == 0 && !dead_mode) begin
          data_ok = 1'b1;
          inst_rdata = memf(pend_addr);
          have_pend = 0;
        end
      end else if (inst_req) begin
        if (a_cnt < a_tgt) begin
          a_cnt++;
        end else begin
          addr_ok = 1'b1;
          a_cnt = 0;
          a_tgt = int'($urandom_range(cfg_amax, cfg_amin));
          lat = int'($urandom_range(cfg_dmax, cfg_dmin));
          if (lat == 0 && !dead_mode) begin
            data_ok = 1'b1;
            inst_rdata = memf(inst_addr);
          end else begin
            have_pend = 1;
            pend_addr = inst_addr;
            d_left = lat;
          end
        end
      end
      prev_req = inst_req;
      prev_aok = addr_ok;
      prev_addr = inst_addr;
    end
  end

  // monitor: every output event must match the head of the scoreboard
  initial begin
    exp_t e;
    int   kind;
    forever begin
      @(negedge clk);
      if (!reset && (fetch_valid || IADEE || IADFE)) begin
        kind = fetch_valid ? K_PAIR : (IADEE ? K_ADE : K_ADF);
        chk("one_event", 32'(fetch_valid) + 32'(IADEE) + 32'(IADFE), 1);
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_out: kind=%0d pc=%h expected none",
                   kind, fetch_pc);
        end else begin
          e = sb.pop_front();
          chk("out_kind", 32'(kind), 32'(e.kind));
          chk("out_pc", fetch_pc, e.pc);
          if (e.kind == K_PAIR) begin
            chk("out_inst1", if_inst_1, e.w1);
            chk("out_inst2", if_inst_2, e.w2);
          end
        end
      end
    end
  end

  task automatic run_txn(input logic [31:0] pc, input int fl);
    int n;
    @(negedge clk);
    fetch_en = 1'b1;
    fetch_pc_in = pc;
    flush = (fl == 0);
    if (fl != 0) begin
      if (pc[1:0] != 2'b00) push_fault(K_ADE, pc);
      else if (fl < 0 && dead_mode) push_fault(K_ADF, pc);
      else if (fl < 0) push_pair(pc);
    end
    @(negedge clk);
    fetch_en = 1'b0;
    flush = (fl == 1);
    @(negedge clk);
    flush = (fl == 2);
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (delay_hard && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_chk++;
      n_err++;
      $display("FAIL txn_timeout: delay_hard=%0b expected 0", delay_hard);
    end
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation ran %0t expected end earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, pc;
    int fl;
    bit dead;
    reset = 1'b1;
    fetch_en = 1'b0;
    fetch_pc_in = '0;
    flush = 1'b0;
    last_w1 = '0;
    last_w2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", inst_req, 0);
    chk("rst_addr", inst_addr, 0);
    chk("rst_dh", delay_hard, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_pc", fetch_pc, 0);
    chk("rst_if1", if_inst_1, 0);
    chk("rst_faults", {IADEE, IADFE}, 0);
    reset = 1'b0;
    @(negedge clk);

    set_cfg(0, 0, 1, 1, 0);
    @(negedge clk);
    fetch_en = 1'b1;
    fetch_pc_in = RESET_PC;
    push_pair(RESET_PC);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      fetch_en = 1'b0;
      chk($sformatf("zw_req_c%0d", k), inst_req, zw_req[k]);
      chk($sformatf("zw_dh_c%0d", k), delay_hard, zw_dh[k]);
      chk($sformatf("zw_fv_c%0d", k), fetch_valid, zw_fv[k]);
      if (k == 1) chk("zw_addr0", inst_addr, 32'h1FC0_0000);
      if (k == 3) chk("zw_addr1", inst_addr, 32'h1FC0_0004);
    end

    @(negedge clk);
    fetch_en = 1'b1;
    fetch_pc_in = 32'hBFC0_0002;
    push_fault(K_ADE, 32'hBFC0_0002);
    @(negedge clk);
    fetch_en = 1'b0;
    chk("ade_pulse", IADEE, 1);
    chk("ade_req", inst_req, 0);
    chk("ade_dh", delay_hard, 0);
    @(negedge clk);
    chk("ade_end", IADEE, 0);
    chk("ade_req2", inst_req, 0);

    set_cfg(3, 3, 2, 2, 0);
    run_txn(32'h8000_1000, -1);

    set_cfg(0, 0, 3, 3, 0);
    @(negedge clk);
    fetch_en = 1'b1;
    fetch_pc_in = 32'h8000_2000;
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    chk("drn_dh_c2", delay_hard, 1);
    @(negedge clk);
    flush = 1'b0;
    chk("drn_dh_c3", delay_hard, 1);
    @(negedge clk);
    chk("drn_dh_c4", delay_hard, 1);
    @(negedge clk);
    chk("drn_dh_c5", delay_hard, 0);
    chk("drn_req_c5", inst_req, 0);
    chk("drn_keep1", if_inst_1, last_w1);
    set_cfg(0, 0, 1, 1, 0);
    run_txn(32'h8000_3000, -1);

    @(negedge clk);
    fetch_en = 1'b1;
    fetch_pc_in = 32'h8000_4000;
    repeat (4) @(negedge clk);
    fetch_en = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("done_flush_fv", fetch_valid, 0);
    chk("done_flush_dh", delay_hard, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    last_w1 = memf(phys(32'h8000_4000));
    last_w2 = memf(phys(32'h8000_4004));

    set_cfg(0, 0, 1, 1, 1);
    @(negedge clk);
    fetch_en = 1'b1;
    fetch_pc_in = 32'h8000_5000;
    push_fault(K_ADF, 32'h8000_5000);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      fetch_en = 1'b0;
      if (k == 9) begin
        chk("tmo_pre", IADFE, 0);
        chk("tmo_pre_dh", delay_hard, 1);
      end
      if (k == 10) begin
        chk("tmo_pulse", IADFE, 1);
        chk("tmo_dh", delay_hard, 0);
        chk("tmo_keep1", if_inst_1, last_w1);
        chk("tmo_keep2", if_inst_2, last_w2);
      end
    end
    @(negedge clk);
    chk("tmo_end", IADFE, 0);

    set_cfg(0, 0, 1, 1, 0);
    @(negedge clk);
    fetch_en = 1'b1;
    fetch_pc_in = 32'hFFFF_FFFC;
    push_pair(32'hFFFF_FFFC);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      fetch_en = 1'b0;
      if (k == 1) begin
        chk("wrap_d0_addr0", d0_addr, 32'hFFFF_FFFC);
        chk("wrap_d0_req", d0_req, 1);
      end
      if (k == 3) begin
        chk("wrap_d0_addr1", d0_addr, 32'h0000_0000);
        chk("wrap_addr1", inst_addr, 32'h0000_0000);
      end
      if (k == 5) begin
        chk("wrap_d0_fv", d0_fv, 1);
        chk("wrap_d0_pc", d0_pc, 32'hFFFF_FFFC);
        chk("wrap_d0_if1", d0_if1, memf(32'h1FFF_FFFC));
        chk("wrap_d0_if2", d0_if2, memf(32'h0000_0000));
        chk("wrap_d0_flt", {d0_ade, d0_adf, d0_dh}, 0);
      end
    end

    set_cfg(0, 3, 0, 3, 0);
    for (int t = 0; t < 150; t++) begin
      r = $urandom();
      pc = {r[31:2], 2'b00};
      if ($urandom_range(7) == 0) pc[1:0] = 2'($urandom_range(3, 1));
      dead = ($urandom_range(9) == 0);
      fl = -1;
      if (!dead && $urandom_range(4) == 0) fl = int'($urandom_range(2));
      set_cfg(0, 3, 0, 3, dead);
      run_txn(pc, fl);
    end

    set_cfg(0, 0, 3, 3, 0);
    @(negedge clk);
    fetch_en = 1'b1;
    fetch_pc_in = 32'h8000_6000;
    repeat (6) @(negedge clk);
    fetch_en = 1'b0;
    chk("rst_w1_dh", delay_hard, 1);
    chk("rst_w1_req", inst_req, 0);
    reset = 1'b1;
    #1;
    chk("arst_req", inst_req, 0);
    chk("arst_addr", inst_addr, 0);
    chk("arst_dh", delay_hard, 0);
    chk("arst_if1", if_inst_1, 0);
    chk("arst_if2", if_inst_2, 0);
    chk("arst_pc", fetch_pc, 0);
    chk("arst_flags", {fetch_valid, IADEE, IADFE}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_dok_if1", if_inst_1, 0);
    chk("late_dok_dh", delay_hard, 0);
    chk("late_dok_sb", 32'(sb.size()), 0);
    set_cfg(0, 0, 1, 1, 0);
    run_txn(RESET_PC, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
